// File: rtl/player_if.sv
// Player controller bus: keycode slots in, sprite/weapon status out.
// master = keyboard/consumer side, slave = player_ctrl.
interface player_if #(
    parameter int N_KEYS   = 2,
    parameter int MAG_SIZE = 6
);
    localparam int AMMO_W = $clog2(MAG_SIZE + 1);

    logic [8*N_KEYS-1:0] keycodes;
    logic [9:0]          PlayerX;
    logic [9:0]          PlayerY;
    logic [9:0]          PlayerS;
    logic [1:0]          Direction;
    logic                shoot;
    logic [AMMO_W-1:0]   Ammo;
    logic                reloading;

    modport master (
        output keycodes,
        input  PlayerX, PlayerY, PlayerS, Direction, shoot, Ammo, reloading
    );

    modport slave (
        input  keycodes,
        output PlayerX, PlayerY, PlayerS, Direction, shoot, Ammo, reloading
    );
endinterface

// File: rtl/player_ctrl.sv
// Frame-rate player sprite controller: multi-key 8-way movement with edge
// clamping, facing direction, and a magazine/cooldown/reload weapon FSM.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// READY     | weapon armed; a fire edge shoots, reload key starts reload
// COOLDOWN  | shot just fired; waits out the inter-shot gap
// EMPTY     | magazine exhausted; only reload leaves this state
// RELOADING | refilling the magazine; all weapon keys ignored
module player_ctrl #(
    parameter int         N_KEYS          = 2,
    parameter int         X_CENTER        = 320,
    parameter int         Y_CENTER        = 240,
    parameter int         X_MIN           = 0,
    parameter int         X_MAX           = 639,
    parameter int         Y_MIN           = 0,
    parameter int         Y_MAX           = 479,
    parameter int         SIZE            = 4,
    parameter int         STEP            = 1,
    parameter int         MAG_SIZE        = 6,
    parameter int         COOLDOWN_FRAMES = 8,
    parameter int         RELOAD_FRAMES   = 60,
    parameter logic [7:0] KEY_LEFT        = 8'h04,
    parameter logic [7:0] KEY_RIGHT       = 8'h07,
    parameter logic [7:0] KEY_DOWN        = 8'h16,
    parameter logic [7:0] KEY_UP          = 8'h1A,
    parameter logic [7:0] KEY_FIRE        = 8'h2C,
    parameter logic [7:0] KEY_RELOAD      = 8'h15
) (
    input  logic     frame_clk,
    input  logic     Reset_n,
    player_if.slave  bus
);

    localparam int AMMO_W  = $clog2(MAG_SIZE + 1);
    localparam int CNT_MAX = (COOLDOWN_FRAMES > RELOAD_FRAMES) ? COOLDOWN_FRAMES : RELOAD_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]  CD_LOAD  = CNT_W'(COOLDOWN_FRAMES - 1);
    localparam logic [CNT_W-1:0]  RL_LOAD  = CNT_W'(RELOAD_FRAMES - 1);
    localparam logic [AMMO_W-1:0] AMMO_FULL = AMMO_W'(MAG_SIZE);
    localparam logic [AMMO_W-1:0] AMMO_ONE  = AMMO_W'(1);

    // Clamp limits keep the whole sprite on screen; 12-bit signed math
    // avoids any 10-bit wrap when stepping below 0 or above 1023.
    localparam logic signed [11:0] X_LO   = 12'(X_MIN + SIZE);
    localparam logic signed [11:0] X_HI   = 12'(X_MAX - SIZE);
    localparam logic signed [11:0] Y_LO   = 12'(Y_MIN + SIZE);
    localparam logic signed [11:0] Y_HI   = 12'(Y_MAX - SIZE);
    localparam logic signed [11:0] STEP_S = 12'(STEP);

    typedef enum logic [1:0] {
        READY     = 2'd0,
        COOLDOWN  = 2'd1,
        EMPTY     = 2'd2,
        RELOADING = 2'd3
    } weapon_state_t;

    weapon_state_t     state;
    logic [CNT_W-1:0]  cnt;
    logic [AMMO_W-1:0] ammo;
    logic              shoot_r;
    logic              reloading_r;
    logic              fire_prev;

    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] dir;

    logic              held_left, held_right, held_down, held_up;
    logic              held_fire, held_reload;
    logic [7:0]        slot;
    logic              fire_edge;
    logic              reload_ok;
    logic signed [11:0] x_sum, y_sum;
    logic [9:0]        x_next, y_next;

    // Key decode: a key is held if any slot carries its code.
    always_comb begin
        held_left   = 1'b0;
        held_right  = 1'b0;
        held_down   = 1'b0;
        held_up     = 1'b0;
        held_fire   = 1'b0;
        held_reload = 1'b0;
        slot        = 8'h00;
        for (int i = 0; i < N_KEYS; i++) begin
            slot = bus.keycodes[8*i +: 8];
            if (slot == KEY_LEFT)   held_left   = 1'b1;
            if (slot == KEY_RIGHT)  held_right  = 1'b1;
            if (slot == KEY_DOWN)   held_down   = 1'b1;
            if (slot == KEY_UP)     held_up     = 1'b1;
            if (slot == KEY_FIRE)   held_fire   = 1'b1;
            if (slot == KEY_RELOAD) held_reload = 1'b1;
        end
    end

    assign fire_edge = held_fire && !fire_prev;
    assign reload_ok = held_reload && (ammo < AMMO_FULL);

    // Next position: step each axis by this frame's keys, then clamp.
    always_comb begin
        x_sum = $signed({2'b00, pos_x});
        y_sum = $signed({2'b00, pos_y});
        if (held_right && !held_left)
            x_sum = x_sum + STEP_S;
        else if (held_left && !held_right)
            x_sum = x_sum - STEP_S;
        if (held_down && !held_up)
            y_sum = y_sum + STEP_S;
        else if (held_up && !held_down)
            y_sum = y_sum - STEP_S;

        if (x_sum < X_LO)
            x_next = X_LO[9:0];
        else if (x_sum > X_HI)
            x_next = X_HI[9:0];
        else
            x_next = x_sum[9:0];

        if (y_sum < Y_LO)
            y_next = Y_LO[9:0];
        else if (y_sum > Y_HI)
            y_next = Y_HI[9:0];
        else
            y_next = y_sum[9:0];
    end

    // Position and facing register, updated every frame.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pos_x <= 10'(X_CENTER);
            pos_y <= 10'(Y_CENTER);
            dir   <= 2'd0;
        end else begin
            pos_x <= x_next;
            pos_y <= y_next;
            if (held_up)
                dir <= 2'd3;
            else if (held_down)
                dir <= 2'd2;
            else if (held_left)
                dir <= 2'd0;
            else if (held_right)
                dir <= 2'd1;
        end
    end

    // Weapon FSM with registered shoot/ammo/reloading outputs.
    // Cooldown returns to READY on the frame its counter reaches zero, so a
    // new fire edge can land exactly COOLDOWN_FRAMES frames after a shot.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= READY;
            cnt         <= '0;
            ammo        <= AMMO_FULL;
            shoot_r     <= 1'b0;
            reloading_r <= 1'b0;
            fire_prev   <= 1'b0;
        end else begin
            fire_prev <= held_fire;
            shoot_r   <= 1'b0;
            case (state)
                READY: begin
                    if (fire_edge && ammo != '0) begin
                        shoot_r <= 1'b1;
                        ammo    <= ammo - AMMO_ONE;
                        if (ammo == AMMO_ONE) begin
                            state <= EMPTY;
                        end else if (COOLDOWN_FRAMES > 1) begin
                            state <= COOLDOWN;
                            cnt   <= CD_LOAD;
                        end
                    end else if (reload_ok) begin
                        state       <= RELOADING;
                        cnt         <= RL_LOAD;
                        reloading_r <= 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (reload_ok) begin
                        state       <= RELOADING;
                        cnt         <= RL_LOAD;
                        reloading_r <= 1'b1;
                    end else if (cnt <= CNT_W'(1)) begin
                        state <= READY;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                EMPTY: begin
                    if (reload_ok) begin
                        state       <= RELOADING;
                        cnt         <= RL_LOAD;
                        reloading_r <= 1'b1;
                    end
                end
                RELOADING: begin
                    if (cnt == '0) begin
                        state       <= READY;
                        ammo        <= AMMO_FULL;
                        reloading_r <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state       <= READY;
                    cnt         <= '0;
                    reloading_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PlayerX   = pos_x;
    assign bus.PlayerY   = pos_y;
    assign bus.PlayerS   = 10'(SIZE);
    assign bus.Direction = dir;
    assign bus.shoot     = shoot_r;
    assign bus.Ammo      = ammo;
    assign bus.reloading = reloading_r;

endmodule

// File: tb/tb_player_ctrl.sv
// Directed bench for player_ctrl: reset, motion, clamping, fire/cooldown,
// empty/reload, reload priority and asynchronous reset mid-reload.
module tb_player_ctrl;

    localparam logic [15:0] K_NONE   = 16'h0000;
    localparam logic [15:0] K_DW     = 16'h071A;
    localparam logic [15:0] K_AD     = 16'h0407;
    localparam logic [15:0] K_D      = 16'h0007;
    localparam logic [15:0] K_A      = 16'h0004;
    localparam logic [15:0] K_W      = 16'h001A;
    localparam logic [15:0] K_FIRE   = 16'h002C;
    localparam logic [15:0] K_RELOAD = 16'h0015;
    localparam logic [15:0] K_FR     = 16'h2C15;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    player_if #(.N_KEYS(2), .MAG_SIZE(6)) bus ();

    player_ctrl dut (
        .frame_clk (clk),
        .Reset_n   (rst_n),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply keys, then run n frames; samples land 1 time unit after each edge.
    task automatic press(input logic [15:0] k, input int n);
        bus.keycodes = k;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        bus.keycodes = K_NONE;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        press(K_NONE, 1);
        n_cmp++; if (bus.PlayerX !== 10'd320) begin n_bad++; $display("FAIL reset_x got %0d want 320", bus.PlayerX); end
        n_cmp++; if (bus.PlayerY !== 10'd240) begin n_bad++; $display("FAIL reset_y got %0d want 240", bus.PlayerY); end
        n_cmp++; if (bus.PlayerS !== 10'd4) begin n_bad++; $display("FAIL reset_size got %0d want 4", bus.PlayerS); end
        n_cmp++; if (bus.Direction !== 2'd0) begin n_bad++; $display("FAIL reset_dir got %0d want 0", bus.Direction); end
        n_cmp++; if (bus.Ammo !== 3'd6) begin n_bad++; $display("FAIL reset_ammo got %0d want 6", bus.Ammo); end
        n_cmp++; if (bus.shoot !== 1'b0) begin n_bad++; $display("FAIL reset_shoot got %b want 0", bus.shoot); end
        n_cmp++; if (bus.reloading !== 1'b0) begin n_bad++; $display("FAIL reset_reloading got %b want 0", bus.reloading); end
    endtask

    task automatic test_diagonal;
        press(K_DW, 10);
        n_cmp++; if (bus.PlayerX !== 10'd330) begin n_bad++; $display("FAIL diag_x got %0d want 330", bus.PlayerX); end
        n_cmp++; if (bus.PlayerY !== 10'd230) begin n_bad++; $display("FAIL diag_y got %0d want 230", bus.PlayerY); end
        n_cmp++; if (bus.Direction !== 2'd3) begin n_bad++; $display("FAIL diag_dir got %0d want 3", bus.Direction); end
        press(K_AD, 5);
        n_cmp++; if (bus.PlayerX !== 10'd330) begin n_bad++; $display("FAIL cancel_x got %0d want 330", bus.PlayerX); end
        n_cmp++; if (bus.PlayerY !== 10'd230) begin n_bad++; $display("FAIL cancel_y got %0d want 230", bus.PlayerY); end
        n_cmp++; if (bus.Direction !== 2'd0) begin n_bad++; $display("FAIL cancel_dir got %0d want 0", bus.Direction); end
        press(K_NONE, 3);
        n_cmp++; if (bus.Direction !== 2'd0) begin n_bad++; $display("FAIL hold_dir got %0d want 0", bus.Direction); end
    endtask

    task automatic test_clamp;
        press(K_D, 300);
        n_cmp++; if (bus.PlayerX !== 10'd630) begin n_bad++; $display("FAIL right_run_x got %0d want 630", bus.PlayerX); end
        n_cmp++; if (bus.Direction !== 2'd1) begin n_bad++; $display("FAIL right_dir got %0d want 1", bus.Direction); end
        for (int i = 0; i < 20; i++) begin
            press(K_D, 1);
            n_cmp++; if (bus.PlayerX > 10'd635) begin n_bad++; $display("FAIL right_overshoot frame %0d got %0d want <=635", i, bus.PlayerX); end
        end
        n_cmp++; if (bus.PlayerX !== 10'd635) begin n_bad++; $display("FAIL right_clamp_x got %0d want 635", bus.PlayerX); end
        press(K_A, 630);
        n_cmp++; if (bus.PlayerX !== 10'd5) begin n_bad++; $display("FAIL left_run_x got %0d want 5", bus.PlayerX); end
        for (int i = 0; i < 10; i++) begin
            press(K_A, 1);
            n_cmp++; if (bus.PlayerX !== 10'd4) begin n_bad++; $display("FAIL left_clamp frame %0d got %0d want 4", i, bus.PlayerX); end
        end
        press(K_W, 300);
        n_cmp++; if (bus.PlayerY !== 10'd4) begin n_bad++; $display("FAIL top_clamp_y got %0d want 4", bus.PlayerY); end
        press(K_NONE, 1);
    endtask

    task automatic test_hold_fire;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            press(K_FIRE, 1);
            if (bus.shoot === 1'b1) pulses++;
        end
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL hold_fire_pulses got %0d want 1", pulses); end
        n_cmp++; if (bus.Ammo !== 3'd5) begin n_bad++; $display("FAIL hold_fire_ammo got %0d want 5", bus.Ammo); end
        press(K_NONE, 10);
    endtask

    task automatic test_tap_spacing;
        int shots[$];
        for (int k = 0; k < 20; k++) begin
            press((k % 2 == 0) ? K_FIRE : K_NONE, 1);
            if (bus.shoot === 1'b1) shots.push_back(k);
        end
        n_cmp++; if (shots.size() !== 3) begin n_bad++; $display("FAIL tap_count got %0d want 3", shots.size()); end
        if (shots.size() >= 3) begin
            n_cmp++; if (shots[0] !== 0) begin n_bad++; $display("FAIL tap_first got %0d want 0", shots[0]); end
            n_cmp++; if (shots[1] - shots[0] !== 8) begin n_bad++; $display("FAIL tap_gap1 got %0d want 8", shots[1] - shots[0]); end
            n_cmp++; if (shots[2] - shots[1] !== 8) begin n_bad++; $display("FAIL tap_gap2 got %0d want 8", shots[2] - shots[1]); end
        end
        n_cmp++; if (bus.Ammo !== 3'd2) begin n_bad++; $display("FAIL tap_ammo got %0d want 2", bus.Ammo); end
        press(K_NONE, 10);
    endtask

    task automatic test_empty_reload;
        int hi;
        press(K_FIRE, 1);
        n_cmp++; if (bus.shoot !== 1'b1) begin n_bad++; $display("FAIL empty_shot5 got %b want 1", bus.shoot); end
        press(K_NONE, 9);
        press(K_FIRE, 1);
        n_cmp++; if (bus.shoot !== 1'b1 || bus.Ammo !== 3'd0) begin n_bad++; $display("FAIL empty_shot6 got shoot=%b ammo=%0d want 1/0", bus.shoot, bus.Ammo); end
        press(K_NONE, 9);
        press(K_FIRE, 1);
        n_cmp++; if (bus.shoot !== 1'b0) begin n_bad++; $display("FAIL empty_no_pulse got %b want 0", bus.shoot); end
        n_cmp++; if (bus.Ammo !== 3'd0) begin n_bad++; $display("FAIL empty_ammo got %0d want 0", bus.Ammo); end
        press(K_NONE, 1);
        press(K_RELOAD, 1);
        hi = 0;
        for (int i = 0; i < 200 && bus.reloading === 1'b1; i++) begin
            hi++;
            press(K_NONE, 1);
        end
        n_cmp++; if (hi !== 60) begin n_bad++; $display("FAIL reload_frames got %0d want 60", hi); end
        n_cmp++; if (bus.Ammo !== 3'd6) begin n_bad++; $display("FAIL reload_ammo got %0d want 6", bus.Ammo); end
        press(K_FIRE, 1);
        n_cmp++; if (bus.shoot !== 1'b1 || bus.Ammo !== 3'd5) begin n_bad++; $display("FAIL post_reload_fire got shoot=%b ammo=%0d want 1/5", bus.shoot, bus.Ammo); end
    endtask

    task automatic test_reload_priority;
        int hi;
        // Reload during cooldown overrides the cooldown.
        press(K_NONE, 2);
        press(K_RELOAD, 1);
        n_cmp++; if (bus.reloading !== 1'b1) begin n_bad++; $display("FAIL cooldown_reload got %b want 1", bus.reloading); end
        hi = 1;
        for (int i = 0; i < 200 && bus.reloading === 1'b1; i++) begin
            press(K_NONE, 1);
            if (bus.reloading === 1'b1) hi++;
        end
        n_cmp++; if (hi !== 60 || bus.Ammo !== 3'd6) begin n_bad++; $display("FAIL cooldown_reload_done got frames=%0d ammo=%0d want 60/6", hi, bus.Ammo); end
        // Full magazine: reload ignored.
        press(K_RELOAD, 3);
        n_cmp++; if (bus.reloading !== 1'b0) begin n_bad++; $display("FAIL full_reload got %b want 0", bus.reloading); end
        press(K_NONE, 1);
        for (int s = 0; s < 3; s++) begin
            press(K_FIRE, 1);
            press(K_NONE, 9);
        end
        n_cmp++; if (bus.Ammo !== 3'd3) begin n_bad++; $display("FAIL prio_setup_ammo got %0d want 3", bus.Ammo); end
        press(K_FR, 1);
        n_cmp++; if (bus.shoot !== 1'b1) begin n_bad++; $display("FAIL prio_shoot got %b want 1", bus.shoot); end
        n_cmp++; if (bus.Ammo !== 3'd2) begin n_bad++; $display("FAIL prio_ammo got %0d want 2", bus.Ammo); end
        n_cmp++; if (bus.reloading !== 1'b0) begin n_bad++; $display("FAIL prio_reloading got %b want 0", bus.reloading); end
        press(K_NONE, 2);
        press(K_FIRE, 1);
        n_cmp++; if (bus.shoot !== 1'b0 || bus.reloading !== 1'b0) begin n_bad++; $display("FAIL prio_cooldown got shoot=%b reloading=%b want 0/0", bus.shoot, bus.reloading); end
        press(K_NONE, 10);
    endtask

    task automatic test_reset_mid_reload;
        press(K_RELOAD, 1);
        n_cmp++; if (bus.reloading !== 1'b1) begin n_bad++; $display("FAIL mid_reload_start got %b want 1", bus.reloading); end
        press(K_NONE, 10);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.reloading !== 1'b0 || bus.Ammo !== 3'd6) begin n_bad++; $display("FAIL async_reset got reloading=%b ammo=%0d want 0/6", bus.reloading, bus.Ammo); end
        n_cmp++; if (bus.PlayerX !== 10'd320 || bus.PlayerY !== 10'd240) begin n_bad++; $display("FAIL async_reset_pos got %0d,%0d want 320,240", bus.PlayerX, bus.PlayerY); end
        #1;
        rst_n = 1'b1;
        press(K_NONE, 1);
        n_cmp++; if (bus.PlayerX !== 10'd320 || bus.PlayerY !== 10'd240) begin n_bad++; $display("FAIL release_pos got %0d,%0d want 320,240", bus.PlayerX, bus.PlayerY); end
        n_cmp++; if (bus.Ammo !== 3'd6 || bus.reloading !== 1'b0 || bus.shoot !== 1'b0) begin n_bad++; $display("FAIL release_weapon got ammo=%0d reloading=%b shoot=%b want 6/0/0", bus.Ammo, bus.reloading, bus.shoot); end
        n_cmp++; if (bus.Direction !== 2'd0) begin n_bad++; $display("FAIL release_dir got %0d want 0", bus.Direction); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        bus.keycodes = K_NONE;
        #1;
        test_reset;
        test_diagonal;
        test_clamp;
        test_hold_fire;
        test_tap_spacing;
        test_empty_reload;
        test_reload_priority;
        test_reset_mid_reload;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
